multicore_rr: RTL and testbench

- Parametrised successor to the fixed 46-core rede_taylor array.
- Instantiates NUM_CORES rede_taylor cores sharing one io_in stream, and releases their resets one at a time on a programmable stagger.
- Replaces the lossy priority output mux with per-core capture slots and a round-robin arbiter, so simultaneous core outputs are never dropped.
- Exposes a single registered result stream with core tag, plus overflow diagnostics.

---
 rtl/multicore_rr_pkg.sv | 24 ++
 rtl/multicore_rr_if.sv | 40 ++++
 rtl/multicore_rr_arbiter.sv | 35 +++
 rtl/rede_taylor.sv | 73 +++++++
 rtl/multicore_rr.sv | 173 +++++++++++++++++
 tb/tb_multicore_rr.sv | 298 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/multicore_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicore_pkg
// Purpose  : Shared widths, sequencer state type and index-width helper for
//            the multicore_rr array.
// Revision : 1.0 - initial release
// ============================================================================
package multicore_pkg;

    localparam int IN_W_D  = 19;
    localparam int OUT_W_D = 28;
    localparam int EN_W_D  = 4;

    typedef enum logic [0:0] {
        S_RELEASE = 1'b0,
        S_RUN     = 1'b1
    } seq_state_e;

    function automatic int core_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicore_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : multicore_rr_if
// Purpose  : Sample input, per-core requests and arbitrated result stream of
//            multicore_rr. ovf_count exists only with MULTICORE_OVF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface multicore_rr_if
    import multicore_pkg::*;
#(
    parameter int NUM_CORES = 46,
    parameter int IN_W      = IN_W_D,
    parameter int OUT_W     = OUT_W_D,
    parameter int EN_W      = EN_W_D
) ();
    localparam int CORE_IDX_W = core_idx_w(NUM_CORES);

    logic signed [IN_W-1:0]       io_in;
    logic [NUM_CORES*EN_W-1:0]    req_in;
    logic signed [OUT_W-1:0]      out_data;
    logic                         out_valid;
    logic [CORE_IDX_W-1:0]        out_core;
    logic [NUM_CORES-1:0]         core_running;
    logic                         all_running;
    logic [NUM_CORES-1:0]         ovf_sticky;
`ifdef MULTICORE_OVF_CNT_EN
    logic [15:0]                  ovf_count;

    modport master (output io_in, input req_in, out_data, out_valid, out_core,
                    core_running, all_running, ovf_sticky, ovf_count);
    modport slave  (input io_in, output req_in, out_data, out_valid, out_core,
                    core_running, all_running, ovf_sticky, ovf_count);
`else
    modport master (output io_in, input req_in, out_data, out_valid, out_core,
                    core_running, all_running, ovf_sticky);
    modport slave  (input io_in, output req_in, out_data, out_valid, out_core,
                    core_running, all_running, ovf_sticky);
`endif
endinterface
`default_nettype wire

// File: rtl/multicore_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first set req bit above ptr,
//            wrapping at N.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import multicore_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = core_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    always_comb begin
        int j;
        j       = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // Walk farthest-first so the nearest requester after ptr wins.
        for (int i = N; i >= 1; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[IW'(j)]) begin
                gnt_idx = IW'(j);
                gnt_any = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rede_taylor.sv
`default_nettype none
// ============================================================================
// Module   : rede_taylor
// Purpose  : Compact rede_taylor core. io_in[18:17] opcode: 1 shifts io_in[13:0]
//            into a staging word, 2 loads it, 3 emits (out_en=1, or 2 when
//            io_in[16]) and post-increments; io_in[CORE_ID%16] selects cores.
// Revision : 1.0 - initial release
// ============================================================================
module rede_taylor #(
    parameter int IN_W    = 19,
    parameter int OUT_W   = 28,
    parameter int EN_W    = 4,
    parameter int CORE_ID = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  io_in,
    output logic [EN_W-1:0]         req_in,
    output logic signed [OUT_W-1:0] io_out,
    output logic [EN_W-1:0]         out_en
);
    localparam logic [1:0] c_OP_SHIFT = 2'd1;
    localparam logic [1:0] c_OP_LOAD  = 2'd2;
    localparam logic [1:0] c_OP_FIRE  = 2'd3;
    localparam int         c_SEL_BIT  = CORE_ID % 16;

    logic [OUT_W-1:0]        sr_q, sr_d, data_q, data_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic [EN_W-1:0]         en_q, en_d;
    logic [1:0]              w_op;
    logic                    w_sel;
    logic                    w_unused;

    assign w_op     = io_in[18:17];
    assign w_sel    = io_in[c_SEL_BIT];
    assign w_unused = ^io_in;

    always_comb begin
        sr_d   = sr_q;
        data_d = data_q;
        out_d  = out_q;
        en_d   = '0;
        case (w_op)
            c_OP_SHIFT: sr_d = OUT_W'({sr_q, io_in[13:0]});
            c_OP_LOAD:  if (w_sel) data_d = sr_q;
            c_OP_FIRE:  if (w_sel) begin
                out_d  = data_q;
                data_d = data_q + OUT_W'(1);
                en_d   = io_in[16] ? EN_W'(2) : EN_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            data_q <= '0;
            out_q  <= '0;
            en_q   <= '0;
        end else begin
            sr_q   <= sr_d;
            data_q <= data_d;
            out_q  <= out_d;
            en_q   <= en_d;
        end
    end

    assign req_in = data_q[EN_W-1:0];
    assign io_out = out_q;
    assign out_en = en_q;
endmodule
`default_nettype wire

// File: rtl/multicore_rr.sv
`default_nettype none
// ============================================================================
// Module   : multicore_rr
// Purpose  : NUM_CORES rede_taylor cores with staggered reset release and a
//            lossless round-robin result collector. MULTICORE_OVF_CNT_EN adds
//            a saturating overflow event counter (ovf_count).
// Revision : 1.0 - initial release
// ============================================================================
module multicore_rr
    import multicore_pkg::*;
#(
    parameter int NUM_CORES      = 46,
    parameter int IN_W           = IN_W_D,
    parameter int OUT_W          = OUT_W_D,
    parameter int EN_W           = EN_W_D,
    parameter int STAGGER_CYCLES = 7
) (
    input  logic           clk,
    input  logic           rst,
    multicore_rr_if.slave  bus
);
    localparam int CORE_IDX_W = core_idx_w(NUM_CORES);
    localparam int CNT_W      = (STAGGER_CYCLES <= 1) ? 1 : $clog2(STAGGER_CYCLES);
    localparam logic [CNT_W-1:0]      c_CNT_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CORE_IDX_W-1:0] c_IDX_LAST = CORE_IDX_W'(NUM_CORES - 1);

    seq_state_e              state_q;
    logic [CORE_IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_CORES-1:0]    running_q;
    logic                    all_running_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RELEASE;
            idx_q         <= '0;
            cnt_q         <= '0;
            running_q     <= '0;
            all_running_q <= 1'b0;
        end else begin
            case (state_q)
                S_RELEASE: begin
                    if (cnt_q == '0) begin
                        running_q[idx_q] <= 1'b1;
                        if (idx_q == c_IDX_LAST) begin
                            state_q       <= S_RUN;
                            all_running_q <= 1'b1;
                        end
                    end
                    if (cnt_q == c_CNT_LAST) begin
                        cnt_q <= '0;
                        idx_q <= idx_q + CORE_IDX_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    logic signed [OUT_W-1:0] w_io_out [NUM_CORES];
    logic [EN_W-1:0]         w_out_en [NUM_CORES];
    logic [NUM_CORES-1:0]    w_cap;

    generate
        for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
            rede_taylor #(
                .IN_W    (IN_W),
                .OUT_W   (OUT_W),
                .EN_W    (EN_W),
                .CORE_ID (k)
            ) u_core (
                .clk    (clk),
                .rst    (rst | ~running_q[k]),
                .io_in  (bus.io_in),
                .req_in (bus.req_in[k*EN_W +: EN_W]),
                .io_out (w_io_out[k]),
                .out_en (w_out_en[k])
            );
            assign w_cap[k] = running_q[k] & (w_out_en[k] == EN_W'(1));
        end
    endgenerate

    logic [NUM_CORES-1:0]    pending_q, pending_d, ovf_q, ovf_d, w_ovf_evt;
    logic signed [OUT_W-1:0] slot_q [NUM_CORES];
    logic signed [OUT_W-1:0] slot_d [NUM_CORES];
    logic [CORE_IDX_W-1:0]   ptr_q, ptr_d, out_core_q, out_core_d, w_gnt;
    logic                    w_gnt_any, out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req     (pending_q),
        .ptr     (ptr_q),
        .gnt_idx (w_gnt),
        .gnt_any (w_gnt_any)
    );

    // The grant reads the pre-edge slot, so a same-cycle capture on the granted
    // core simply refills it and is not an overflow.
    always_comb begin
        pending_d   = pending_q;
        slot_d      = slot_q;
        ptr_d       = ptr_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_core_d  = out_core_q;
        w_ovf_evt   = '0;
        if (w_gnt_any) begin
            out_valid_d      = 1'b1;
            out_data_d       = slot_q[w_gnt];
            out_core_d       = w_gnt;
            ptr_d            = w_gnt;
            pending_d[w_gnt] = 1'b0;
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            if (w_cap[k]) begin
                slot_d[k]    = w_io_out[k];
                pending_d[k] = 1'b1;
                w_ovf_evt[k] = pending_q[k] & ~(w_gnt_any && (w_gnt == CORE_IDX_W'(k)));
            end
        end
        ovf_d = ovf_q | w_ovf_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            ovf_q       <= '0;
            ptr_q       <= c_IDX_LAST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_core_q  <= '0;
            slot_q      <= '{default: '0};
        end else begin
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_core_q  <= out_core_d;
            slot_q      <= slot_d;
        end
    end

`ifdef MULTICORE_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic [16:0] w_cnt_sum;

    always_comb begin
        w_cnt_sum = {1'b0, ovf_cnt_q};
        for (int k = 0; k < NUM_CORES; k++) begin
            w_cnt_sum = w_cnt_sum + 17'(w_ovf_evt[k]);
        end
        ovf_cnt_d = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign bus.ovf_count = ovf_cnt_q;
`endif

    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_core     = out_core_q;
    assign bus.core_running = running_q;
    assign bus.all_running  = all_running_q;
    assign bus.ovf_sticky   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_multicore_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicore_rr
// Purpose  : Directed and random stimulus for multicore_rr (4 cores, stagger 7)
//            against a transaction-level reference of release, capture and
//            round-robin delivery.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicore_rr;
    localparam int NC = 4;
    localparam int S  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicore_rr_if #(.NUM_CORES(NC), .IN_W(19), .OUT_W(28), .EN_W(4)) bus ();

    multicore_rr #(
        .NUM_CORES(NC), .IN_W(19), .OUT_W(28), .EN_W(4), .STAGGER_CYCLES(S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: edges since reset release, per-core core state and slots.
    int          e;
    logic [27:0] m_sr [NC];
    logic [27:0] m_dat[NC];
    logic [27:0] m_out[NC];
    logic [27:0] m_slot[NC];
    logic [3:0]  m_en [NC];
    bit          m_pend[NC];
    int          m_ptr;
    bit [NC-1:0] m_ovf;
    int          m_ovfcnt;
    bit          x_valid;
    logic [27:0] x_data;
    int          x_core;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e = 0; m_ptr = NC - 1; m_ovf = '0; m_ovfcnt = 0;
        x_valid = 0; x_data = '0; x_core = 0;
        for (int k = 0; k < NC; k++) begin
            m_sr[k] = '0; m_dat[k] = '0; m_out[k] = '0; m_slot[k] = '0;
            m_en[k] = '0; m_pend[k] = 0;
        end
    endtask

    task automatic model_edge(input bit r, input logic [18:0] cmd);
        bit run[NC];
        bit cap[NC];
        int g;
        int j;
        for (int k = 0; k < NC; k++) begin
            run[k] = (e >= 1 + k * S);
            cap[k] = run[k] && (m_en[k] == 4'd1);
        end
        g = -1;
        for (int i = 1; i <= NC; i++) begin
            j = (m_ptr + i) % NC;
            if (g < 0 && m_pend[j]) g = j;
        end
        if (r) begin
            model_reset();
            return;
        end
        if (g >= 0) begin
            x_valid = 1; x_data = m_slot[g]; x_core = g; m_ptr = g; m_pend[g] = 0;
        end else begin
            x_valid = 0;
        end
        for (int k = 0; k < NC; k++) begin
            if (cap[k]) begin
                if (m_pend[k]) begin
                    m_ovf[k] = 1'b1;
                    if (m_ovfcnt < 65535) m_ovfcnt++;
                end
                m_slot[k] = m_out[k];
                m_pend[k] = 1;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (!run[k]) begin
                m_sr[k] = '0; m_dat[k] = '0; m_out[k] = '0; m_en[k] = '0;
            end else begin
                m_en[k] = 4'd0;
                case (cmd[18:17])
                    2'd1: m_sr[k] = (m_sr[k] << 14) | 28'(cmd[13:0]);
                    2'd2: if (cmd[k]) m_dat[k] = m_sr[k];
                    2'd3: if (cmd[k]) begin
                        m_out[k] = m_dat[k];
                        m_dat[k] = m_dat[k] + 28'd1;
                        m_en[k]  = cmd[16] ? 4'd2 : 4'd1;
                    end
                    default: ;
                endcase
            end
        end
        e++;
    endtask

    task automatic compare_all();
        logic [NC-1:0]   er;
        logic [NC*4-1:0] rq;
        for (int k = 0; k < NC; k++) begin
            er[k]          = (e >= 1 + k * S);
            rq[k*4 +: 4]   = m_dat[k][3:0];
        end
        check("out_valid",    64'(bus.out_valid),    64'(x_valid));
        check("out_data",     64'({bus.out_data}),   64'(x_data));
        check("out_core",     64'(bus.out_core),     64'(x_core));
        check("core_running", 64'(bus.core_running), 64'(er));
        check("all_running",  64'(bus.all_running),  64'(e >= 1 + (NC - 1) * S));
        check("ovf_sticky",   64'(bus.ovf_sticky),   64'(m_ovf));
        check("req_in",       64'(bus.req_in),       64'(rq));
`ifdef MULTICORE_OVF_CNT_EN
        check("ovf_count",    64'(bus.ovf_count),    64'(m_ovfcnt));
`endif
    endtask

    task automatic tick();
        logic [18:0] cmd;
        bit          r;
        cmd = bus.io_in;
        r   = rst;
        @(posedge clk);
        model_edge(r, cmd);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [1:0] op, input logic bad, input logic [15:0] mask,
                         input logic [13:0] dat);
        logic [18:0] c;
        c = {op, bad, mask};
        if (op == 2'd1) c[13:0] = dat;
        bus.io_in = c;
        tick();
    endtask

    task automatic idle(input int n);
        bus.io_in = '0;
        repeat (n) tick();
    endtask

    task automatic load(input logic [15:0] mask, input logic [27:0] v);
        drive(2'd1, 1'b0, 16'h0, v[27:14]);
        drive(2'd1, 1'b0, 16'h0, v[13:0]);
        drive(2'd2, 1'b0, mask, 14'h0);
    endtask

    task automatic fire(input logic [15:0] mask, input logic bad);
        drive(2'd3, bad, mask, 14'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    initial begin
        int beat;
        bus.io_in = '0;
        model_reset();

        // Reset state and stagger timing.
        do_reset();
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        idle(1);
        check("stagger_e1", 64'(bus.core_running), 64'(4'b0001));
        idle(7);
        check("stagger_e8", 64'(bus.core_running), 64'(4'b0011));
        idle(7);
        check("stagger_e15", 64'(bus.core_running), 64'(4'b0111));
        idle(6);
        check("all_running_e21", 64'(bus.all_running), 64'(0));
        idle(1);
        check("stagger_e22", 64'(bus.core_running), 64'(4'b1111));
        check("all_running_e22", 64'(bus.all_running), 64'(1));

        // Single result: two-cycle latency from out_en.
        load(16'b0100, 28'h8000123);
        fire(16'b0100, 1'b0);
        idle(1);
        check("single_early", 64'(bus.out_valid), 64'(0));
        idle(1);
        check("single_valid", 64'(bus.out_valid), 64'(1));
        check("single_core",  64'(bus.out_core),  64'(2));
        check("single_data",  64'({bus.out_data}), 64'(28'h8000123));
        idle(2);

        // out_en other than 1 is ignored.
        fire(16'b0100, 1'b1);
        idle(2);
        check("bad_en_ignored", 64'(bus.out_valid), 64'(0));
        idle(1);

        // Simultaneous outputs with ptr parked at core 3.
        load(16'b1000, 28'd7);
        fire(16'b1000, 1'b0);
        idle(4);
        load(16'b0001, 28'd5);
        load(16'b0010, 28'hFFFFFFA);
        load(16'b1000, 28'd7);
        fire(16'b1011, 1'b0);
        idle(2);
        check("sim_core0", 64'(bus.out_core), 64'(0));
        check("sim_data0", 64'({bus.out_data}), 64'(28'd5));
        idle(1);
        check("sim_core1", 64'(bus.out_core), 64'(1));
        check("sim_data1", 64'({bus.out_data}), 64'(28'hFFFFFFA));
        idle(1);
        check("sim_core3", 64'(bus.out_core), 64'(3));
        check("sim_data3", 64'({bus.out_data}), 64'(28'd7));
        check("sim_no_ovf", 64'(bus.ovf_sticky), 64'(0));
        idle(2);

        // Overflow: core 1 re-emits while waiting behind core 0.
        load(16'b0001, 28'd20);
        load(16'b0010, 28'd10);
        fire(16'b0011, 1'b0);
        fire(16'b0010, 1'b0);
        idle(1);
        check("ovf_first_core", 64'(bus.out_core), 64'(0));
        check("ovf_first_data", 64'({bus.out_data}), 64'(28'd20));
        idle(1);
        check("ovf_core1_core", 64'(bus.out_core), 64'(1));
        check("ovf_core1_data", 64'({bus.out_data}), 64'(28'd11));
        check("ovf_sticky_set", 64'(bus.ovf_sticky), 64'(4'b0010));
`ifdef MULTICORE_OVF_CNT_EN
        check("ovf_count_one", 64'(bus.ovf_count), 64'(1));
`endif
        idle(1);
        check("ovf_no_extra", 64'(bus.out_valid), 64'(0));

        // Reset mid-stagger with core 0 pending.
        do_reset();
        idle(1);
        load(16'b0001, 28'd99);
        idle(3);
        fire(16'b0001, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(1);
        check("midrst_valid",   64'(bus.out_valid),    64'(0));
        check("midrst_running", 64'(bus.core_running), 64'(0));
        check("midrst_ovf",     64'(bus.ovf_sticky),   64'(0));
        check("midrst_data",    64'({bus.out_data}),   64'(0));
        rst = 1'b0;
        idle(1);
        check("midrst_no_stale", 64'(bus.out_valid),   64'(0));
        check("midrst_restart",  64'(bus.core_running), 64'(4'b0001));
        idle(21);

        // Fairness: every core emits every cycle.
        beat = 0;
        for (int c = 0; c < 22; c++) begin
            if (c < 16) begin
                bus.io_in = {2'd3, 1'b0, 16'h000F};
                tick();
            end else begin
                idle(1);
            end
            if (bus.out_valid) begin
                check("rr_order", 64'(bus.out_core), 64'(beat % NC));
                beat++;
            end
        end
        check("rr_all_ovf", 64'(bus.ovf_sticky), 64'(4'hF));

        // Random commands with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            bus.io_in = 19'($urandom);
            tick();
        end
        rst = 1'b0;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
